alu_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one combinational 16-bit ALU (`alu_16_bit`: operands a/b, 4-bit opcode, enable, 16-bit result) between NUM_REQ requesters. Each requester presents an operation with a valid/ready handshake. The scheduler grants one requester at a time, latches its operands, drives the ALU for ALU_LAT cycles, and returns the captured result on a shared response channel tagged with the requester index. It sits between the requesting units and the single `alu_16_bit` instance.

---
 rtl/alu_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 39 +++
 rtl/alu_rr_scheduler.sv | 134 +++++++++++++
 tb/tb_alu_rr_scheduler.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the round-robin ALU scheduler.
package alu_sched_pkg;

    // Scheduler FSM states: waiting for a request, driving the ALU, offering the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 16;
    localparam int OPW_DEF   = 4;
    // Wide enough for ALU_LAT-1 with ALU_LAT up to 15.
    localparam int LAT_W     = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: priority starts just after 'last',
// wraps around and ends at 'last' itself. Grants nothing while en is low.
module rr_arbiter
    import alu_sched_pkg::*;
#(
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] last,
    input  logic           en,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    // Scan requesters in rotating priority order and grant the first one found.
    always_comb begin
        logic           found_s;
        int             sum_s;
        logic [IDW-1:0] idx_s;
        gnt     = '0;
        gnt_id  = '0;
        found_s = 1'b0;
        sum_s   = 0;
        idx_s   = '0;
        for (int k = 1; k <= N; k++) begin
            sum_s = int'(last) + k;
            idx_s = (sum_s >= N) ? IDW'(sum_s - N) : IDW'(sum_s);
            if (en && !found_s && req[idx_s]) begin
                found_s    = 1'b1;
                gnt[idx_s] = 1'b1;
                gnt_id     = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU between NUM_REQ requesters. One operation is
// in flight at a time: grant in IDLE, hold ALU inputs for ALU_LAT cycles in
// EXEC, then present the tagged result in RESP until it is taken.
module alu_rr_scheduler
    import alu_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = WIDTH_DEF,
    parameter int OPW     = OPW_DEF,
    parameter int ALU_LAT = 1,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*OPW-1:0] req_op,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [WIDTH-1:0]       rsp_result,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [OPW-1:0]         alu_opcode,
    output logic                   alu_en,
    input  logic [WIDTH-1:0]       alu_result,
    output logic                   busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [OPW-1:0]   opcode_q, opcode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [LAT_W-1:0] lat_q, lat_d;
    logic [NUM_REQ-1:0] gnt_s;
    logic [IDW-1:0]   gnt_id_s;
    logic             arb_en_s;

    // Grants are only offered in IDLE; reset also masks them so every output is quiet during reset.
    assign arb_en_s = (state_q == ST_IDLE) && rst_n;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req    (req_valid),
        .last   (last_q),
        .en     (arb_en_s),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s)
    );

    assign req_ready  = gnt_s;
    assign rsp_valid  = (state_q == ST_RESP);
    assign alu_en     = (state_q == ST_EXEC);
    assign busy       = (state_q != ST_IDLE);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    // Operand registers drive the ALU directly, so they hold their value outside EXEC.
    assign alu_a      = op_a_q;
    assign alu_b      = op_b_q;
    assign alu_opcode = opcode_q;

    // Next-state and datapath register updates for the three-phase operation.
    always_comb begin
        state_d  = state_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        opcode_d = opcode_q;
        result_d = result_q;
        id_d     = id_q;
        last_d   = last_q;
        lat_d    = lat_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt_s) begin
                    op_a_d   = req_a[int'(gnt_id_s) * WIDTH +: WIDTH];
                    op_b_d   = req_b[int'(gnt_id_s) * WIDTH +: WIDTH];
                    opcode_d = req_op[int'(gnt_id_s) * OPW +: OPW];
                    id_d     = gnt_id_s;
                    last_d   = gnt_id_s;
                    lat_d    = LAT_W'(ALU_LAT - 1);
                    state_d  = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (lat_q == '0) begin
                    result_d = alu_result;
                    state_d  = ST_RESP;
                end else begin
                    lat_d = lat_q - LAT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_a_q   <= '0;
            op_b_q   <= '0;
            opcode_q <= '0;
            result_q <= '0;
            id_q     <= '0;
            last_q   <= IDW'(NUM_REQ - 1);
            lat_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
            id_q     <= id_d;
            last_q   <= last_d;
            lat_q    <= lat_d;
        end
    end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: one instance with ALU_LAT=1 and one with ALU_LAT=4,
// each driving a model ALU, checked against directed expectations and a
// transaction-level reference model.
module tb_alu_rr_scheduler;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int OW  = 4;
    localparam int IDW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0, req_valid4 = '0;
    logic [N*W-1:0]  req_a = '0, req_b = '0;
    logic [N*OW-1:0] req_op = '0;
    logic            rsp_ready = 1'b0, rsp_ready4 = 1'b0;

    logic [N-1:0]   req_ready, req_ready4;
    logic           rsp_valid, rsp_valid4, alu_en, alu_en4, busy, busy4;
    logic [IDW-1:0] rsp_id, rsp_id4;
    logic [W-1:0]   rsp_result, rsp_result4, alu_a, alu_a4, alu_b, alu_b4, alu_result, alu_result4;
    logic [OW-1:0]  alu_opcode, alu_opcode4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Model ALU behaviour: opcode 0 add, 1 xor, 2 and, 3 or, others zero.
    function automatic logic [W-1:0] ref_alu(logic [W-1:0] a, logic [W-1:0] b, logic [OW-1:0] op);
        case (op)
            4'd0: return a + b;
            4'd1: return a ^ b;
            4'd2: return a & b;
            4'd3: return a | b;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic int oh_idx(logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    assign alu_result  = ref_alu(alu_a, alu_b, alu_opcode);
    assign alu_result4 = ref_alu(alu_a4, alu_b4, alu_opcode4);

    alu_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .OPW(OW), .ALU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_en(alu_en),
        .alu_result(alu_result), .busy(busy)
    );

    alu_rr_scheduler #(.NUM_REQ(N), .WIDTH(W), .OPW(OW), .ALU_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_id(rsp_id4), .rsp_result(rsp_result4),
        .alu_a(alu_a4), .alu_b(alu_b4), .alu_opcode(alu_opcode4), .alu_en(alu_en4),
        .alu_result(alu_result4), .busy(busy4)
    );

    task automatic do_reset();
        rst_n = 1'b0; req_valid = '0; req_valid4 = '0; rsp_ready = 1'b0; rsp_ready4 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_slot(int i, logic [W-1:0] a, logic [W-1:0] b, logic [OW-1:0] op);
        req_a[i*W +: W] = a; req_b[i*W +: W] = b; req_op[i*OW +: OW] = op;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = 4'hF; req_valid4 = 4'hF;
        #1;
        total++; if (req_ready !== 4'h0 || req_ready4 !== 4'h0) begin bad++; $display("FAIL reset_req_ready: got %h/%h expected 0", req_ready, req_ready4); end
        total++; if ({rsp_valid, alu_en, busy, rsp_valid4, alu_en4, busy4} !== 6'b0) begin bad++; $display("FAIL reset_flags: got %b expected 000000", {rsp_valid, alu_en, busy, rsp_valid4, alu_en4, busy4}); end
        total++; if ({rsp_id, rsp_result, alu_a, alu_b, alu_opcode} !== 54'h0) begin bad++; $display("FAIL reset_data: got %h expected 0", {rsp_id, rsp_result, alu_a, alu_b, alu_opcode}); end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        set_slot(2, 16'h0047, 16'h0009, 4'd0);
        req_valid = 4'b0100;
        #1;
        total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant: got %b expected 0100", req_ready); end
        @(negedge clk); req_valid = '0; #1;
        total++; if (alu_en !== 1'b1 || alu_a !== 16'h0047 || alu_b !== 16'h0009 || alu_opcode !== 4'd0) begin bad++; $display("FAIL single_exec: got en=%b a=%h b=%h op=%h expected en=1 a=0047 b=0009 op=0", alu_en, alu_a, alu_b, alu_opcode); end
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL single_exec_flags: got rsp_valid=%b busy=%b expected 0 1", rsp_valid, busy); end
        @(negedge clk); #1;
        total++; if (alu_en !== 1'b0) begin bad++; $display("FAIL single_en_len: got alu_en=%b expected 0", alu_en); end
        total++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 16'h0050) begin bad++; $display("FAIL single_rsp: got v=%b id=%0d r=%h expected v=1 id=2 r=0050", rsp_valid, rsp_id, rsp_result); end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL single_done: got v=%b busy=%b expected 0 0", rsp_valid, busy); end
        rsp_ready = 1'b0;
    endtask

    task automatic test_fairness();
        int gid[$];
        int gcyc[$];
        do_reset();
        for (int i = 0; i < N; i++) set_slot(i, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 3)));
        req_valid = 4'hF; rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            #1;
            if (req_ready !== 4'h0) begin
                total++; if (!$onehot(req_ready)) begin bad++; $display("FAIL fair_onehot: got %b expected one-hot", req_ready); end
                gid.push_back(oh_idx(req_ready)); gcyc.push_back(cyc);
            end
            @(negedge clk);
        end
        req_valid = '0; rsp_ready = 1'b0;
        total++;
        if (gid.size() != 6) begin bad++; $display("FAIL fair_count: got %0d grants expected 6", gid.size()); end
        else begin
            for (int i = 0; i < 6; i++) begin
                total++; if (gid[i] != i % N) begin bad++; $display("FAIL fair_order[%0d]: got %0d expected %0d", i, gid[i], i % N); end
                if (i > 0) begin
                    total++; if (gcyc[i] - gcyc[i-1] != 3) begin bad++; $display("FAIL fair_spacing[%0d]: got %0d expected 3", i, gcyc[i] - gcyc[i-1]); end
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] exp_r;
        bit got = 1'b0;
        do_reset();
        set_slot(0, 16'h1234, 16'h0F0F, 4'd1);
        exp_r = 16'h1234 ^ 16'h0F0F;
        req_valid = 4'b0001;
        @(negedge clk);
        for (int i = 1; i < N; i++) set_slot(i, 16'($urandom), 16'($urandom), 4'd0);
        req_valid = 4'b1110;
        for (int c = 0; c < 10 && !got; c++) begin #1; if (rsp_valid === 1'b1) got = 1'b1; else @(negedge clk); end
        total++; if (!got) begin bad++; $display("FAIL bp_wait: got no rsp_valid expected within 10 cycles"); end
        total++; if (rsp_id !== 2'd0 || rsp_result !== exp_r) begin bad++; $display("FAIL bp_rsp: got id=%0d r=%h expected id=0 r=%h", rsp_id, rsp_result, exp_r); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== exp_r || req_ready !== 4'h0) begin
                bad++; $display("FAIL bp_hold[%0d]: got v=%b id=%0d r=%h rdy=%b expected v=1 id=0 r=%h rdy=0000", c, rsp_valid, rsp_id, rsp_result, req_ready, exp_r);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL bp_next_grant: got %b expected 0010", req_ready); end
        req_valid = '0; rsp_ready = 1'b0;
    endtask

    task automatic test_latency();
        int en_cnt = 0;
        int rv_at = -1;
        do_reset();
        set_slot(0, 16'h00FF, 16'h0F0F, 4'd1);
        req_valid4 = 4'b0001;
        #1;
        total++; if (req_ready4 !== 4'b0001) begin bad++; $display("FAIL lat_grant: got %b expected 0001", req_ready4); end
        @(negedge clk); req_valid4 = '0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (alu_en4 === 1'b1) en_cnt++;
            if (c == 1) begin
                total++; if (alu_a4 !== 16'h00FF || alu_b4 !== 16'h0F0F || alu_opcode4 !== 4'd1) begin bad++; $display("FAIL lat_operands: got a=%h b=%h op=%h expected 00ff 0f0f 1", alu_a4, alu_b4, alu_opcode4); end
            end
            if (rsp_valid4 === 1'b1 && rv_at < 0) rv_at = c;
            @(negedge clk);
        end
        total++; if (en_cnt != 4) begin bad++; $display("FAIL lat_en_cycles: got %0d expected 4", en_cnt); end
        total++; if (rv_at != 5) begin bad++; $display("FAIL lat_rsp_cycle: got %0d expected 5", rv_at); end
        total++; if (rsp_result4 !== 16'h0FF0 || rsp_id4 !== 2'd0) begin bad++; $display("FAIL lat_result: got r=%h id=%0d expected 0ff0 0", rsp_result4, rsp_id4); end
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        do_reset();
        set_slot(2, 16'hAAAA, 16'h5555, 4'd0);
        req_valid = 4'b0100;
        @(negedge clk); req_valid = '0;
        #1;
        total++; if (alu_en !== 1'b1) begin bad++; $display("FAIL rstmid_exec: got alu_en=%b expected 1", alu_en); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({alu_en, busy, rsp_valid, req_ready, alu_a, alu_b, alu_opcode, rsp_result, rsp_id} !== 61'h0) begin
            bad++; $display("FAIL rstmid_outputs: got en=%b busy=%b v=%b a=%h b=%h r=%h expected all 0", alu_en, busy, rsp_valid, alu_a, alu_b, rsp_result);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin #1; if (rsp_valid !== 1'b0) seen = 1'b1; @(negedge clk); end
        total++; if (seen) begin bad++; $display("FAIL rstmid_no_rsp: got rsp_valid=1 expected 0 after reset"); end
        req_valid = 4'b1001;
        #1;
        total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_first_prio: got %b expected 0001", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_withdraw();
        bit saw_g = 1'b0;
        bit saw_id = 1'b0;
        do_reset();
        set_slot(0, 16'h0001, 16'h0002, 4'd0);
        set_slot(1, 16'h0003, 16'h0004, 4'd0);
        req_valid = 4'b0001;
        @(negedge clk); req_valid = '0;
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        total++; if (rsp_valid !== 1'b1 || req_ready !== 4'h0) begin bad++; $display("FAIL wd_resp: got v=%b rdy=%b expected 1 0000", rsp_valid, req_ready); end
        @(negedge clk); req_valid = '0; rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (req_ready[1] === 1'b1) saw_g = 1'b1;
            if (rsp_valid === 1'b1 && rsp_id === 2'd1) saw_id = 1'b1;
            @(negedge clk);
        end
        total++; if (saw_g || saw_id) begin bad++; $display("FAIL wd_never: got grant=%b rsp_id1=%b expected 0 0", saw_g, saw_id); end
        rsp_ready = 1'b0;
    endtask

    // Random traffic against a transaction model: phase 0 idle, 1 executing, 2 responding.
    task automatic test_random();
        int m_phase = 0;
        int m_cnt = 0;
        int m_last = N - 1;
        int m_id = 0;
        int win;
        int clr;
        int nops = 0;
        logic [W-1:0] m_a = '0, m_b = '0, m_res = '0;
        logic [OW-1:0] m_op = '0;
        logic [N-1:0] exp_rdy;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    set_slot(i, 16'($urandom), 16'($urandom), 4'($urandom_range(0, 3)));
                end
            end
            rsp_ready = 1'($urandom_range(0, 1));
            #1;
            win = -1;
            exp_rdy = '0;
            if (m_phase == 0) begin
                for (int k = 1; k <= N && win < 0; k++) begin
                    if (req_valid[(m_last + k) % N]) win = (m_last + k) % N;
                end
                if (win >= 0) exp_rdy[win] = 1'b1;
            end
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, req_ready, exp_rdy); end
            total++; if (alu_en !== (m_phase == 1) || rsp_valid !== (m_phase == 2) || busy !== (m_phase != 0)) begin
                bad++; $display("FAIL rnd_flags@%0d: got en=%b v=%b busy=%b expected phase %0d", cyc, alu_en, rsp_valid, busy, m_phase);
            end
            if (m_phase == 1) begin
                total++; if (alu_a !== m_a || alu_b !== m_b || alu_opcode !== m_op) begin bad++; $display("FAIL rnd_alu_in@%0d: got %h %h %h expected %h %h %h", cyc, alu_a, alu_b, alu_opcode, m_a, m_b, m_op); end
            end
            if (m_phase == 2) begin
                total++; if (rsp_id !== 2'(m_id) || rsp_result !== m_res) begin bad++; $display("FAIL rnd_rsp@%0d: got id=%0d r=%h expected id=%0d r=%h", cyc, rsp_id, rsp_result, m_id, m_res); end
            end
            clr = -1;
            case (m_phase)
                0: if (win >= 0) begin
                    m_a = req_a[win*W +: W]; m_b = req_b[win*W +: W]; m_op = req_op[win*OW +: OW];
                    m_id = win; m_last = win; m_cnt = 1; m_phase = 1; clr = win;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) begin m_res = ref_alu(m_a, m_b, m_op); m_phase = 2; end
                end
                default: if (rsp_ready) begin m_phase = 0; nops++; end
            endcase
            @(negedge clk);
            if (clr >= 0) req_valid[clr] = 1'b0;
        end
        req_valid = '0; rsp_ready = 1'b0;
        total++; if (nops < 20) begin bad++; $display("FAIL rnd_progress: got %0d completed expected at least 20", nops); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_latency();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
